// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: load-use stalls, branch flushes,
// dmem wait-state stalls with a sticky timeout error, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_wb,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   wait_cnt, wait_nxt;
  logic             err_nxt;
  logic             mwait;
  logic             load_use;

  assign mwait = mem_access & ~dmem_ready;

  // A zero destination never produces a real dependency.
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_timeout_err;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    bubble_wb = 1'b0;

    case (state)
      RUN: begin
        if (mwait) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mwait) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WCW'(1);
        end
      end
      ERR: ;
      default: state_nxt = RUN;
    endcase

    // A taken branch waiting on dmem stays in EX and flushes once the wait ends.
    if (!rst) begin
      if (state == ERR || mwait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_mem = 1'b1;
        bubble_wb = 1'b1;
      end else if (ex_branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_count     <= '0;
      flush_count     <= '0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_nxt;
      mem_timeout_err <= err_nxt;
      if (stall_if && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_id && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with a short timeout and narrow counters
// so timeout entry and counter saturation are reached in a few cycles.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_WAIT = 6'b111001;
  localparam logic [5:0] C_LU   = 6'b100010;
  localparam logic [5:0] C_BR   = 6'b000110;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken;
  logic          mem_access, dmem_ready;
  logic          stall_if, stall_id, stall_mem, flush_id, flush_ex, bubble_wb;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_count, flush_count;
  logic [5:0]    ctl;

  int checks   = 0;
  int failures = 0;

  assign ctl = {stall_if, stall_id, stall_mem, flush_id, flush_ex, bubble_wb};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
    .mem_timeout_err(mem_timeout_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use();
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    // Reset with a pending memory wait on the inputs
    clear_inputs();
    rst = 1'b1;
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    tick();
    tick();
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    rst = 1'b0;
    #2;
    chk("rel_wait_ctl", 32'(ctl), 32'(C_WAIT));
    tick();
    chk("rel_stall_cnt", 32'(stall_count), 32'd1);
    dmem_ready = 1'b1;
    #2;
    chk("rel_ready_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("rel_stall_cnt2", 32'(stall_count), 32'd1);

    // Load-use on rs2
    do_reset();
    set_load_use();
    #2;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    ex_MemRead = 1'b0;
    #2;
    chk("lu_clear_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("lu_stall_cnt_hold", 32'(stall_count), 32'd1);
    // x0 destination is never a hazard
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    #2;
    chk("lu_x0_ctl", 32'(ctl), 32'(C_NONE));
    // rs1 match, then same match with rs1 unused
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    #2;
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    id_uses_rs1 = 1'b0;
    #2;
    chk("lu_rs1_unused_ctl", 32'(ctl), 32'(C_NONE));
    ex_MemRead = 1'b0; id_uses_rs1 = 1'b1;
    #2;
    chk("lu_not_load_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("lu_stall_cnt_end", 32'(stall_count), 32'd1);

    // Branch overrides load-use
    do_reset();
    set_load_use();
    ex_branch_taken = 1'b1;
    #2;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_count), 32'd0);

    // Memory wait defers a taken branch
    do_reset();
    ex_branch_taken = 1'b1;
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("mw_ctl_%0d", i), 32'(ctl), 32'(C_WAIT));
      tick();
    end
    chk("mw_stall_cnt", 32'(stall_count), 32'd3);
    chk("mw_flush_cnt", 32'(flush_count), 32'd0);
    dmem_ready = 1'b1;
    #2;
    chk("mw_release_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("mw_flush_cnt2", 32'(flush_count), 32'd1);
    chk("mw_stall_cnt2", 32'(stall_count), 32'd3);
    chk("mw_err", 32'(mem_timeout_err), 32'd0);

    // Timeout: error set on the edge ending the fifth wait cycle
    do_reset();
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      chk($sformatf("to_err_edge%0d", i), 32'(mem_timeout_err), (i == TO + 1) ? 32'd1 : 32'd0);
    end
    chk("to_stall_cnt", 32'(stall_count), 32'd5);
    dmem_ready = 1'b1;
    ex_branch_taken = 1'b1;
    #2;
    chk("to_err_ctl", 32'(ctl), 32'(C_WAIT));
    for (int i = 0; i < 3; i++) tick();
    chk("to_err_sticky", 32'(mem_timeout_err), 32'd1);
    chk("to_stall_sat", 32'(stall_count), 32'd7);
    chk("to_flush_cnt", 32'(flush_count), 32'd0);
    rst = 1'b1;
    #1;
    chk("to_rst_err", 32'(mem_timeout_err), 32'd0);
    chk("to_rst_ctl", 32'(ctl), 32'(C_NONE));
    rst = 1'b0;
    #1;
    chk("to_after_rst_ctl", 32'(ctl), 32'(C_BR));

    // Stall counter saturation
    do_reset();
    set_load_use();
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", i), 32'(stall_count), (i < 7) ? 32'(i) : 32'd7);
    end

    // Reset in the middle of a wait
    do_reset();
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    tick();
    tick();
    chk("mid_pre_cnt", 32'(stall_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("mid_rst_cnt", 32'(stall_count), 32'd0);
    mem_access = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_run_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("mid_run_cnt", 32'(stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
